// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the HI/LO multiply-divide unit: operation encodings,
// default latencies, counter width and the FSM state type.
package mult_div_unit_pkg;

  localparam logic [1:0] MDU_OP_MULTU = 2'b00;
  localparam logic [1:0] MDU_OP_MULT  = 2'b01;
  localparam logic [1:0] MDU_OP_DIVU  = 2'b10;
  localparam logic [1:0] MDU_OP_DIV   = 2'b11;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;
  localparam int MDU_CNT_W           = 16;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Two's complement negation, shared by the signed divide path.
  function automatic logic [31:0] mdu_neg32(input logic [31:0] value);
    return ~value + 32'd1;
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// mdu_divider: combinational 32-bit signed/unsigned quotient and remainder.
// Signed results truncate toward zero; the remainder follows the dividend's sign.
module mdu_divider
  import mult_div_unit_pkg::*;
(
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] safe_b_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;

  // Divide magnitudes, then restore signs; a zero divisor is replaced so the
  // datapath never produces X, the caller discards the result in that case.
  always_comb begin
    neg_a_s     = is_signed & dividend[31];
    neg_b_s     = is_signed & divisor[31];
    mag_a_s     = neg_a_s ? mdu_neg32(dividend) : dividend;
    mag_b_s     = neg_b_s ? mdu_neg32(divisor) : divisor;
    div_by_zero = (divisor == 32'd0);
    safe_b_s    = div_by_zero ? 32'd1 : mag_b_s;
    uq_s        = mag_a_s / safe_b_s;
    ur_s        = mag_a_s % safe_b_s;
    quotient    = (neg_a_s ^ neg_b_s) ? mdu_neg32(uq_s) : uq_s;
    remainder   = neg_a_s ? mdu_neg32(ur_s) : ur_s;
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit with MTHI/MTLO writes.
// Divide support is compiled in only when macro MDU_DIV_EN is defined.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mulOp,
  input  logic        mulWe,
  input  logic        HiLo,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MDU_CNT_W-1:0] CNT_ONE   = MDU_CNT_W'(1);
  localparam logic [MDU_CNT_W-1:0] MULT_LOAD = MDU_CNT_W'(MULT_CYCLES);

  mdu_state_e           state_r;
  mdu_state_e           next_state_s;
  logic [MDU_CNT_W-1:0] count_r;
  logic [MDU_CNT_W-1:0] load_s;
  logic                 busy_r;
  logic [31:0]          hi_r;
  logic [31:0]          lo_r;
  logic [31:0]          pend_hi_r;
  logic [31:0]          pend_lo_r;
  logic                 pend_valid_r;
  logic [63:0]          product_s;
  logic [63:0]          result_s;
  logic                 result_valid_s;
  logic                 op_ok_s;
  logic                 accept_s;
  logic                 direct_we_s;
  logic                 finish_s;

  // 64-bit product; sign-extending both operands makes the low 64 bits signed-correct.
  always_comb begin
    if (mulOp[0]) begin
      product_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    end else begin
      product_s = {32'd0, A} * {32'd0, B};
    end
  end

`ifdef MDU_DIV_EN
  localparam logic [MDU_CNT_W-1:0] DIV_LOAD = MDU_CNT_W'(DIV_CYCLES);

  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic        div_zero_s;

  mdu_divider u_divider (
    .dividend    (A),
    .divisor     (B),
    .is_signed   (mulOp[0]),
    .quotient    (quot_s),
    .remainder   (rem_s),
    .div_by_zero (div_zero_s)
  );

  // Select pending result and latency; divide by zero still runs but never commits.
  always_comb begin
    op_ok_s = 1'b1;
    if (mulOp[1]) begin
      result_s       = {rem_s, quot_s};
      result_valid_s = ~div_zero_s;
      load_s         = DIV_LOAD;
    end else begin
      result_s       = product_s;
      result_valid_s = 1'b1;
      load_s         = MULT_LOAD;
    end
  end
`else
  // Divide opcodes are rejected outright when the divider is not built.
  always_comb begin
    op_ok_s        = ~mulOp[1];
    result_s       = product_s;
    result_valid_s = 1'b1;
    load_s         = MULT_LOAD;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= MDU_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      MDU_IDLE: begin
        if (accept_s) begin
          next_state_s = MDU_RUN;
        end else begin
          next_state_s = MDU_IDLE;
        end
      end
      MDU_RUN: begin
        if (finish_s) begin
          next_state_s = MDU_IDLE;
        end else begin
          next_state_s = MDU_RUN;
        end
      end
      default: next_state_s = MDU_IDLE;
    endcase
  end

  // FSM control outputs; start beats mulWe, and neither is honoured while running.
  always_comb begin
    accept_s    = 1'b0;
    direct_we_s = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      MDU_IDLE: begin
        accept_s    = start & op_ok_s;
        direct_we_s = mulWe & ~start;
      end
      MDU_RUN: begin
        finish_s = (count_r == CNT_ONE);
      end
      default: begin
        accept_s    = 1'b0;
        direct_we_s = 1'b0;
        finish_s    = 1'b0;
      end
    endcase
  end

  // Countdown, pending result capture and architectural HI/LO update.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r      <= '0;
      busy_r       <= 1'b0;
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
      pend_hi_r    <= 32'd0;
      pend_lo_r    <= 32'd0;
      pend_valid_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s == MDU_RUN);
      if (accept_s) begin
        count_r      <= load_s;
        pend_hi_r    <= result_s[63:32];
        pend_lo_r    <= result_s[31:0];
        pend_valid_r <= result_valid_s;
      end else if (state_r == MDU_RUN) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
      if (finish_s && pend_valid_r) begin
        hi_r <= pend_hi_r;
        lo_r <= pend_lo_r;
      end else if (direct_we_s) begin
        if (HiLo) begin
          hi_r <= A;
        end else begin
          lo_r <= A;
        end
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a driver pushes expected {hi, lo, busy length}
// from an arithmetic reference model, a monitor compares when the unit goes idle.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mulOp;
  logic        mulWe;
  logic        HiLo;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_tests = 0;
  int          n_fail  = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mulOp (mulOp),
    .mulWe (mulWe),
    .HiLo  (HiLo),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    end
  endtask

  task automatic check_len(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s busy_len: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: counts busy cycles, compares once the unit is idle again.
  initial begin
    int    run_len;
    exp_t  e;
    string nm;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        if (busy === 1'b1) begin
          run_len++;
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check32({nm, " hi"}, hi, e.hi);
          check32({nm, " lo"}, lo, e.lo);
          check_len(nm, run_len, e.len);
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
    end
  end

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int len);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    len = 0;
    if (!op[1]) begin
      if (op[0]) up = longint'(sa * sb);
      else       up = ua * ub;
      m_hi = up[63:32];
      m_lo = up[31:0];
      len  = MULT_N;
    end else if (DIV_EN) begin
      len = DIV_N;
      if (b != 32'd0) begin
        if (op[0]) begin
          sq = sa / sb;
          sr = sa % sb;
          q  = sq;
          r  = sr;
        end else begin
          q = ua / ub;
          r = ua % ub;
        end
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
    end
  endtask

  task automatic push_exp(input string nm, input int len);
    exp_t e;
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.len = len;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got %0d pending checks, expected 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // Start an operation; optionally poke start/mulWe poke_at cycles into the busy period.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic we, input logic hl,
                        input int poke_at, input logic poke_start, input logic poke_we);
    int len;
    model_op(op, a, b, len);
    mulOp = op; A = a; B = b; start = 1'b1; mulWe = we; HiLo = hl;
    @(posedge clk); #1;
    start = 1'b0; mulWe = 1'b0;
    push_exp(nm, len);
    if (poke_at > 0 && poke_at < len) begin
      repeat (poke_at - 1) begin
        @(posedge clk); #1;
      end
      start = poke_start; mulWe = poke_we; HiLo = 1'b1;
      mulOp = 2'b01; A = 32'hDEADBEEF; B = 32'h00000003;
      @(posedge clk); #1;
      start = 1'b0; mulWe = 1'b0;
    end
    drain(nm);
  endtask

  task automatic run_we(input string nm, input logic hl, input logic [31:0] a);
    if (hl) m_hi = a;
    else    m_lo = a;
    start = 1'b0; mulWe = 1'b1; HiLo = hl; A = a;
    @(posedge clk); #1;
    mulWe = 1'b0;
    push_exp(nm, 0);
    drain(nm);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h00000001;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; mulWe = 1'b0; HiLo = 1'b0;
    mulOp = 2'b00; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    push_exp("reset_state", 0);
    drain("reset_state");

    run_op("multu_max",   2'b00, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op("mult_neg",    2'b01, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op("div_neg",     2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_we("mthi_idle",   1'b1, 32'h12345678);
    run_op("divu_zero",   2'b10, 32'd7, 32'd0, 1'b0, 1'b0, 3, 1'b0, 1'b1);
    run_we("mtlo_idle",   1'b0, 32'hCAFEF00D);
    run_op("mult_we_busy", 2'b01, 32'd5, 32'd6, 1'b0, 1'b0, 2, 1'b0, 1'b1);
    run_op("mult_restart", 2'b01, 32'd100, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    run_op("div_ovf",     2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op("start_and_we", 2'b00, 32'd3, 32'd4, 1'b1, 1'b1, 0, 1'b0, 1'b0);

    // Reset in the middle of an operation: cleared at once, nothing committed later.
    mulOp = DIV_EN ? 2'b11 : 2'b01; A = 32'hFFFFFFF9; B = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    push_exp("mid_reset", 0);
    drain("mid_reset");
    repeat (15) begin
      @(posedge clk); #1;
    end
    push_exp("post_reset_idle", 0);
    drain("post_reset_idle");

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      case ($urandom_range(0, 5))
        4:       run_we("rand_we", 1'($urandom_range(0, 1)), ra);
        5:       run_op("rand_op_we", rop, ra, rb, 1'b1, 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
        default: run_op("rand_op", rop, ra, rb, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL have the parameter MULT_CYCLES, default 5, meaning the number of busy cycles for MULT/MULTU.
REQ-002 The module SHALL have the parameter DIV_CYCLES, default 10, meaning the number of busy cycles for DIV/DIVU.
REQ-003 The module SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have the port start, input, 1 bit: launch the operation selected by mulOp (from the E-stage decoder).
REQ-006 The module SHALL have the port mulOp, input, 2 bits, encoded as: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 The module SHALL have the port mulWe, input, 1 bit: direct write of A into HI or LO (MTHI/MTLO).
REQ-008 The module SHALL have the port HiLo, input, 1 bit: target of mulWe (1 = HI, 0 = LO).
REQ-009 The module SHALL have the ports A and B, input, 32 bits each: forwarded rs and rt operands.
REQ-010 The module SHALL have the port busy, output, 1 bit: an operation is in flight.
REQ-011 The module SHALL have the ports hi and lo, output, 32 bits each: architectural HI and LO registers.

Function
REQ-012 When start=1 is sampled while busy=0, the block SHALL capture A, B and mulOp, compute the result into pending registers, and load a countdown with MULT_CYCLES or DIV_CYCLES.
REQ-013 busy SHALL be 1 for exactly N cycles, starting the cycle after the start edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-014 hi and lo SHALL take the pending result on the same edge that busy falls, so no stale value is visible after busy=0.
REQ-015 MULTU/MULT SHALL produce {hi,lo} = the 64-bit unsigned or signed product of A×B.
REQ-016 DIVU/DIV SHALL write lo = quotient and hi = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-017 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-018 Division by zero SHALL take the full DIV_CYCLES busy period and leave hi and lo unchanged.
REQ-019 When mulWe=1 while busy=0 and start=0, the block SHALL write A into hi if HiLo=1, otherwise into lo, on that edge with no busy period.
REQ-020 start or mulWe arriving while busy=1 SHALL be ignored; the ID-stage stall logic is responsible for holding such instructions.
REQ-021 When start and mulWe are both 1 in the same cycle, start SHALL win and mulWe SHALL be ignored.
REQ-022 The block SHALL be a two-state FSM: IDLE goes to RUN on an accepted start; RUN decrements the count and returns to IDLE when the count reaches 1, committing the result.

Reset
REQ-023 reset=1 SHALL force hi=0, lo=0, busy=0, state IDLE and the count to 0 on the next edge, taking priority over all inputs.
REQ-024 A reset asserted mid-operation SHALL cancel the operation, and the pending result SHALL never be committed.

Configuration
REQ-025 With macro MDU_DIV_EN defined, the block SHALL implement DIVU and DIV as specified above.
REQ-026 Without MDU_DIV_EN, a start with mulOp=1x SHALL be ignored (no busy period, hi and lo unchanged), no divider logic SHALL be synthesized, and DIV_CYCLES SHALL be unused.

Structure
REQ-027 The mulOp encodings and the default MULT_CYCLES and DIV_CYCLES values SHALL be kept as named constants in the shared defines file used by the decode controllers.
REQ-028 The block SHALL contain one sub-module, mdu_divider: combinational 32-bit signed/unsigned quotient and remainder, instantiated only under MDU_DIV_EN.

Verification
REQ-029 The bench SHALL cover: MULTU with A=0xFFFFFFFF, B=2 -> busy high for exactly 5 cycles, then hi=0x00000001 and lo=0xFFFFFFFE in the cycle busy falls.
REQ-030 The bench SHALL cover: MULT with A=-3, B=7 -> hi=0xFFFFFFFF and lo=0xFFFFFFEB after 5 cycles.
REQ-031 The bench SHALL cover: DIV with A=-7, B=2 -> busy for 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU with A=7, B=0 -> 10 busy cycles, hi and lo unchanged.
REQ-032 The bench SHALL cover: mulWe=1, HiLo=1, A=0x12345678 while idle -> hi=0x12345678 on the next cycle, busy stays 0; the same while busy -> ignored.
REQ-033 The bench SHALL cover: a second start 2 cycles into a MULT -> ignored, the busy length stays 5, and the first result is committed.
REQ-034 The bench SHALL cover: reset asserted in cycle 3 of a DIV -> next cycle busy=0, hi=0 and lo=0, and nothing is committed afterwards.
